// File: rtl/countdown_timer_10bit.sv
// countdown_timer_10bit: 10-bit down-counter with an IDLE / COUNT / EXPIRED FSM.
// A start loads count_value and the count falls by one per clock. Pause freezes
// the count, abort returns the timer to idle, and done pulses for one cycle at expiry.
// Build option: define COUNTDOWN_AUTO_RELOAD_EN to reload count_value at expiry and
// keep counting instead of stopping in EXPIRED.
module countdown_timer_10bit (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic       abort,
    input  logic       pause,
    input  logic [9:0] count_value,
    output logic [9:0] count,
    output logic       busy,
    output logic       done,
    output logic       expired
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COUNT   = 2'd1,
        ST_EXPIRED = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [9:0] count_q, count_d;
    logic       done_q,  done_d;

    // State, count and done registers; reset clears everything without waiting for a clock edge.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            count_q <= 10'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic. Priority order is abort, then start, then pause, then decrement.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = 1'b0;

        if (abort) begin
            // Abort is silent: the timer goes back to idle and done does not pulse.
            state_d = ST_IDLE;
            count_d = 10'd0;
        end else if (start) begin
            // A start is honoured in every state. In COUNT it restarts the count.
            if (count_value == 10'd0) begin
                state_d = ST_EXPIRED;
                count_d = 10'd0;
                done_d  = 1'b1;
            end else begin
                state_d = ST_COUNT;
                count_d = count_value;
            end
        end else begin
            case (state_q)
                ST_COUNT: begin
                    if (!pause) begin
                        // COUNT never holds a zero count, so a value of 1 marks the final decrement.
                        if (count_q <= 10'd1) begin
                            done_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                            // The reload samples count_value as it is now.
                            // A zero value expires the timer instead of reloading it.
                            if (count_value == 10'd0) begin
                                state_d = ST_EXPIRED;
                                count_d = 10'd0;
                            end else begin
                                state_d = ST_COUNT;
                                count_d = count_value;
                            end
`else
                            state_d = ST_EXPIRED;
                            count_d = 10'd0;
`endif
                        end else begin
                            count_d = count_q - 10'd1;
                        end
                    end
                end
                ST_IDLE, ST_EXPIRED: begin
                    // Pause has no effect in these states, and the count stays at zero.
                    count_d = 10'd0;
                end
                default: begin
                    state_d = ST_IDLE;
                    count_d = 10'd0;
                end
            endcase
        end
    end

    assign count   = count_q;
    assign done    = done_q;
    assign busy    = (state_q == ST_COUNT);
    assign expired = (state_q == ST_EXPIRED);

endmodule

// File: tb/tb_countdown_timer_10bit.sv
// Testbench for countdown_timer_10bit.
// It applies a vector table, then hand-written corner sequences, then random
// stimulus. Every cycle is checked against a behavioural model of the timer.
module tb_countdown_timer_10bit;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       pause = 1'b0;
    logic [9:0] count_value = 10'd0;
    logic [9:0] count;
    logic       busy, done, expired;

    int checks = 0;
    int errors = 0;

    countdown_timer_10bit dut (
        .clock      (clock),
        .resetn     (resetn),
        .start      (start),
        .abort      (abort),
        .pause      (pause),
        .count_value(count_value),
        .count      (count),
        .busy       (busy),
        .done       (done),
        .expired    (expired)
    );

    always #5 clock = ~clock;

    // Behavioural model. Mode 0 is idle, 1 is counting and 2 is expired.
    int m_mode  = 0;
    int m_count = 0;
    int m_done  = 0;

    task automatic model_edge(input bit st, input bit ab, input bit pa, input int cv);
        m_done = 0;
        if (ab) begin
            m_mode  = 0;
            m_count = 0;
        end else if (st) begin
            if (cv == 0) begin
                m_mode  = 2;
                m_count = 0;
                m_done  = 1;
            end else begin
                m_mode  = 1;
                m_count = cv;
            end
        end else if (m_mode == 1 && !pa) begin
            m_count = m_count - 1;
            if (m_count == 0) begin
                m_done = 1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                if (cv == 0) m_mode = 2;
                else m_count = cv;
`else
                m_mode = 2;
`endif
            end
        end
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, req, $time);
        end
    endtask

    // Advance one rising edge, update the model with the inputs that were sampled,
    // then wait 1 time unit before the outputs are read.
    task automatic step_edge();
        @(posedge clock);
        model_edge(start, abort, pause, int'(count_value));
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_count"},   {22'd0, count},   m_count);
        check({tag, "_busy"},    {31'd0, busy},    (m_mode == 1) ? 1 : 0);
        check({tag, "_done"},    {31'd0, done},    m_done);
        check({tag, "_expired"}, {31'd0, expired}, (m_mode == 2) ? 1 : 0);
    endtask

    task automatic drive(input bit st, input bit ab, input bit pa, input int cv);
        start       = st;
        abort       = ab;
        pause       = pa;
        count_value = cv[9:0];
    endtask

    typedef struct {
        bit st; bit ab; bit pa; int cv;
        int e_count; bit e_busy; bit e_done; bit e_exp;
    } vec_t;

    function automatic vec_t mk(bit st, bit ab, bit pa, int cv, int ec, bit eb, bit ed, bit ee);
        vec_t v;
        v.st = st; v.ab = ab; v.pa = pa; v.cv = cv;
        v.e_count = ec; v.e_busy = eb; v.e_done = ed; v.e_exp = ee;
        return v;
    endfunction

    vec_t vecs[17];

    initial begin
        int done_at;

        // Vector table: start, abort, pause, count_value, then the expected
        // count, busy, done and expired after the edge.
        vecs[0]  = mk(0,0,0,0,    0,   0,0,0);
        vecs[1]  = mk(1,0,0,3,    3,   1,0,0);
        vecs[2]  = mk(0,0,0,0,    2,   1,0,0);
        vecs[3]  = mk(0,0,1,0,    2,   1,0,0);
        vecs[4]  = mk(0,0,0,0,    1,   1,0,0);
        vecs[5]  = mk(0,0,0,0,    0,   0,1,1);
        vecs[6]  = mk(0,0,1,0,    0,   0,0,1);
        vecs[7]  = mk(1,0,0,0,    0,   0,1,1);
        vecs[8]  = mk(0,0,0,0,    0,   0,0,1);
        vecs[9]  = mk(1,0,0,7,    7,   1,0,0);
        vecs[10] = mk(1,1,0,5,    0,   0,0,0);
        vecs[11] = mk(1,0,0,2,    2,   1,0,0);
        vecs[12] = mk(1,0,1,9,    9,   1,0,0);
        vecs[13] = mk(0,1,0,0,    0,   0,0,0);
        vecs[14] = mk(1,0,0,1023, 1023,1,0,0);
        vecs[15] = mk(0,0,0,0,    1022,1,0,0);
        vecs[16] = mk(0,1,0,0,    0,   0,0,0);

        // All outputs must be cleared while reset is low, before any clock edge.
        #1;
        check("rst_count",   {22'd0, count},   0);
        check("rst_busy",    {31'd0, busy},    0);
        check("rst_done",    {31'd0, done},    0);
        check("rst_expired", {31'd0, expired}, 0);
        #11 resetn = 1'b1;

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].st, vecs[i].ab, vecs[i].pa, vecs[i].cv);
            step_edge();
            check($sformatf("tbl%0d_count", i),   {22'd0, count},   vecs[i].e_count);
            check($sformatf("tbl%0d_busy", i),    {31'd0, busy},    {31'd0, vecs[i].e_busy});
            check($sformatf("tbl%0d_done", i),    {31'd0, done},    {31'd0, vecs[i].e_done});
            check($sformatf("tbl%0d_expired", i), {31'd0, expired}, {31'd0, vecs[i].e_exp});
        end

        // One-shot run with count_value=5: done must appear exactly 5 edges after the start edge.
        drive(1,0,0,5);
        step_edge();
        check_model("os_start");
        drive(0,0,0,5);
        for (int k = 1; k <= 8; k++) begin
            step_edge();
            check_model("os");
            check("os_count_seq", {22'd0, count}, (k <= 5) ? 5 - k : 0);
            check("os_done_time", {31'd0, done}, (k == 5) ? 1 : 0);
`ifndef COUNTDOWN_AUTO_RELOAD_EN
            if (k >= 5) check("os_expired_hold", {31'd0, expired}, 1);
`endif
        end

        // Pause for 3 cycles in the middle of a 4-count: done must move from edge 4 to edge 7.
        drive(1,0,0,4);
        step_edge();
        check_model("pz_start");
        drive(0,0,0,4);
        for (int k = 1; k <= 9; k++) begin
            pause = (k >= 2 && k <= 4);
            step_edge();
            check_model("pz");
            if (k >= 2 && k <= 4) check("pz_frozen", {22'd0, count}, 3);
            check("pz_done_time", {31'd0, done}, (k == 7) ? 1 : 0);
        end
        pause = 1'b0;

        // count_value=0 from idle must expire at once, pulse done and never raise busy.
        drive(0,1,0,0);
        step_edge();
        check_model("zero_abort");
        drive(1,0,0,0);
        step_edge();
        check("zero_busy", {31'd0, busy}, 0);
        check("zero_done", {31'd0, done}, 1);
        check("zero_expired", {31'd0, expired}, 1);
        drive(0,0,0,0);
        step_edge();
        check("zero_done_clear", {31'd0, done}, 0);
        check("zero_busy_after", {31'd0, busy}, 0);

        // Maximum count of 1023: done must appear exactly 1023 edges after the start edge.
        drive(1,0,0,1023);
        step_edge();
        check_model("max_start");
        drive(0,0,0,1023);
        done_at = 0;
        for (int k = 1; k <= 1100 && done_at == 0; k++) begin
            step_edge();
            check_model("max");
            if (done === 1'b1) done_at = k;
        end
        check("max_done_time", done_at, 1023);

        // Drop reset in mid-cycle with count=3: outputs must clear before the next edge,
        // and no done pulse may follow the release of reset.
        drive(1,0,0,5);
        step_edge();
        drive(0,0,0,5);
        step_edge();
        step_edge();
        check("ar_pre_count", {22'd0, count}, 3);
        #2 resetn = 1'b0;
        #1;
        check("ar_count",   {22'd0, count},   0);
        check("ar_busy",    {31'd0, busy},    0);
        check("ar_done",    {31'd0, done},    0);
        check("ar_expired", {31'd0, expired}, 0);
        @(posedge clock);
        #1;
        check("ar_hold_count", {22'd0, count}, 0);
        #3 resetn = 1'b1;
        m_mode = 0; m_count = 0; m_done = 0;
        for (int k = 0; k < 6; k++) begin
            step_edge();
            check_model("ar_post");
            check("ar_no_done", {31'd0, done}, 0);
        end

`ifdef COUNTDOWN_AUTO_RELOAD_EN
        // With auto-reload and count_value=3, done must pulse every 3 cycles and expired must stay low.
        drive(1,0,0,3);
        step_edge();
        check_model("rl_start");
        drive(0,0,0,3);
        for (int k = 1; k <= 13; k++) begin
            step_edge();
            check_model("rl");
            check("rl_done_period", {31'd0, done}, (k % 3 == 0) ? 1 : 0);
            check("rl_expired_low", {31'd0, expired}, 0);
        end
`endif

        // Random stimulus, checked against the model on every edge.
        for (int k = 0; k < 400; k++) begin
            abort = ($urandom_range(0, 19) == 0);
            start = ($urandom_range(0, 7) == 0);
            pause = ($urandom_range(0, 3) == 0);
            count_value = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023))
                                                      : 10'($urandom_range(0, 6));
            step_edge();
            check_model("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog: the bench must always terminate, even if the run above stalls.
    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/countdown_timer_10bit.md
COUNTDOWN_TIMER_10BIT -- requirements
Module: countdown_timer_10bit

Interface
REQ-001 SHALL have port clock, input, 1: single clock, all state changes on rising edge.
REQ-002 SHALL have port resetn, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1: load count_value and begin counting; sampled on each rising edge.
REQ-004 SHALL have port abort, input, 1: cancel any count and return to idle.
REQ-005 SHALL have port pause, input, 1: freeze count while high.
REQ-006 SHALL have port count_value, input, 10: number of decrements to expiry; unsigned 0..1023.
REQ-007 SHALL have port count, output, 10: remaining count, registered.
REQ-008 SHALL have port busy, output, 1: high in state COUNT.
REQ-009 SHALL have port done, output, 1: single-cycle expiry pulse, registered.
REQ-010 SHALL have port expired, output, 1: level, high in state EXPIRED.

Function
REQ-011 SHALL implement states IDLE, COUNT and EXPIRED, each held in a register.
REQ-012 SHALL, on an edge in IDLE or EXPIRED with start=1 and count_value>0, load count=count_value, enter COUNT and clear expired.
REQ-013 SHALL, on an edge in IDLE or EXPIRED with start=1 and count_value=0, enter EXPIRED directly with count=0 and assert done for the following cycle.
REQ-014 SHALL, on an edge in COUNT with start=1, reload count=count_value and remain in COUNT (restart); count_value=0 follows REQ-013.
REQ-015 SHALL, in COUNT with pause=0, decrement count by 1 per edge; with pause=1, hold count and state.
REQ-016 SHALL, on the edge where count goes 1->0, enter EXPIRED and drive done=1 for exactly the next cycle.
REQ-017 SHALL make latency exact: start at edge E with count_value=N>0 and no pause gives done high in the cycle after edge E+N.
REQ-018 SHALL give abort priority over start and pause: abort=1 at any edge forces IDLE, count=0, busy=0, expired=0, with no done pulse.
REQ-019 SHALL give start priority over pause in COUNT: start with pause reloads.
REQ-020 SHALL ignore pause in IDLE and EXPIRED.
REQ-021 SHALL hold count at 0 in IDLE and EXPIRED; count SHALL never wrap below 0 or exceed 1023.
REQ-022 SHALL hold EXPIRED until start or abort.

Reset
REQ-023 SHALL, while resetn=0, immediately force state IDLE, count=10'd0, busy=0, done=0, expired=0, independent of clock.
REQ-024 SHALL, on reset mid-count, discard the count, and SHALL NOT emit done on reset release.

Configuration
REQ-025 SHALL support macro COUNTDOWN_AUTO_RELOAD_EN.
REQ-026 SHALL, with COUNTDOWN_AUTO_RELOAD_EN defined, on the 1->0 edge of REQ-016, reload count=count_value (current input) and stay in COUNT while still pulsing done; expired then never asserts, except when the reloaded count_value=0, which enters EXPIRED per REQ-013.
REQ-027 SHALL, with COUNTDOWN_AUTO_RELOAD_EN undefined, behave as one-shot per REQ-016 and REQ-022.

Verification
REQ-028 SHALL check one-shot: start, count_value=5, no pause -> count 5,4,3,2,1,0; done high exactly 1 cycle, 5 cycles after the start edge; expired stays high.
REQ-029 SHALL check pause: count_value=4, pause high 3 cycles mid-count -> done delayed exactly 3 cycles; count frozen during pause.
REQ-030 SHALL check zero and max: count_value=0 -> EXPIRED and done next cycle, busy never high; count_value=1023 -> done after 1023 cycles.
REQ-031 SHALL check priority: abort and start same edge at count=7 -> IDLE, count=0, no done; start at count=2 with count_value=9 -> count=9, no done.
REQ-032 SHALL check async reset: resetn low mid-cycle at count=3 -> outputs zero before next edge; no done after release.
REQ-033 SHALL check auto-reload build: count_value=3 -> done every 3 cycles for at least 4 periods, expired=0 throughout.
